// File: rtl/feistel_pkg.sv
// Shared types and constants for the 16-bit Feistel round controller.
package feistel_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned RoundsDefault = 16;
    localparam int unsigned SubkeyW       = 8;
    localparam int unsigned BlockW        = 2 * SubkeyW;
    localparam int unsigned KeyW          = 128;
    localparam int unsigned CntW          = 4;

    // Subkey idx is the idx-th byte counted from the MSB end of the key.
    function automatic logic [SubkeyW-1:0] subkey(input logic [KeyW-1:0] key,
                                                  input logic [CntW-1:0] idx);
        logic [KeyW-1:0] sh;
        sh = key << (SubkeyW * idx);
        return sh[KeyW-1 -: SubkeyW];
    endfunction

endpackage

// File: rtl/feistel_round_ctrl_if.sv
// Request/result handshake bundle between a Feistel client and feistel_round_ctrl.
interface feistel_round_ctrl_if;
    import feistel_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BlockW-1:0] pt;
    logic [KeyW-1:0]   key;
    logic              out_valid;
    logic              out_ready;
    logic [BlockW-1:0] ct;
    logic              busy;

    modport master (
        output in_valid, pt, key, out_ready,
        input  in_ready, out_valid, ct, busy
    );

    modport slave (
        input  in_valid, pt, key, out_ready,
        output in_ready, out_valid, ct, busy
    );

endinterface

// File: rtl/feistel_round.sv
// One combinational Feistel round with F(R, K) = R ^ K.
module feistel_round
    import feistel_pkg::*;
(
    input  logic [SubkeyW-1:0] l,
    input  logic [SubkeyW-1:0] r,
    input  logic [SubkeyW-1:0] k,
    output logic [SubkeyW-1:0] l_nxt,
    output logic [SubkeyW-1:0] r_nxt
);

    assign l_nxt = r;
    assign r_nxt = l ^ (r ^ k);

endmodule

// File: rtl/feistel_round_ctrl.sv
// Iterative Feistel block engine: one round per cycle, final half-swap on ct.
// Optional reversed-subkey decryption is enabled by defining FEISTEL_DECRYPT_EN.
module feistel_round_ctrl
    import feistel_pkg::*;
#(
    parameter int unsigned ROUNDS = RoundsDefault
) (
    input logic clk,
    input logic rst_n,
`ifdef FEISTEL_DECRYPT_EN
    input logic decrypt,
`endif
    feistel_round_ctrl_if.slave bus
);

    state_e             state_q, state_d;
    logic [SubkeyW-1:0] l_q, r_q;
    logic [SubkeyW-1:0] l_nxt, r_nxt, k_cur;
    logic [KeyW-1:0]    key_q;
    logic [CntW-1:0]    cnt_q, k_idx;
    logic               accept, last_round;
    logic               in_ready, out_valid, busy;

    assign accept     = (state_q == StIdle) && bus.in_valid;
    assign last_round = (cnt_q == CntW'(ROUNDS - 1));

`ifdef FEISTEL_DECRYPT_EN
    logic dec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else if (accept) begin
            dec_q <= decrypt;
        end
    end

    assign k_idx = dec_q ? (CntW'(ROUNDS - 1) - cnt_q) : cnt_q;
`else
    assign k_idx = cnt_q;
`endif

    assign k_cur = subkey(key_q, k_idx);

    feistel_round u_round (
        .l     (l_q),
        .r     (r_q),
        .k     (k_cur),
        .l_nxt (l_nxt),
        .r_nxt (r_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.in_valid)  state_d = StRun;
            StRun:  if (last_round)    state_d = StDone;
            StDone: if (bus.out_ready) state_d = StIdle;
            default:                   state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle:  in_ready  = 1'b1;
            StRun:   busy      = 1'b1;
            StDone:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // L/R only move on accept or during RUN, so ct stays frozen in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q   <= '0;
            r_q   <= '0;
            key_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            l_q   <= bus.pt[BlockW-1 -: SubkeyW];
            r_q   <= bus.pt[SubkeyW-1:0];
            key_q <= bus.key;
            cnt_q <= '0;
        end else if (state_q == StRun) begin
            l_q   <= l_nxt;
            r_q   <= r_nxt;
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.ct        = {r_q, l_q};

endmodule

// File: tb/tb_feistel_round_ctrl.sv
// Randomized self-checking bench for feistel_round_ctrl against a byte-level Feistel model.
module tb_feistel_round_ctrl;

    localparam int unsigned Rounds = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    feistel_round_ctrl_if bus ();

`ifdef FEISTEL_DECRYPT_EN
    logic decrypt = 1'b0;
`endif

    feistel_round_ctrl #(.ROUNDS(Rounds)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef FEISTEL_DECRYPT_EN
        .decrypt (decrypt),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: split the key into bytes, walk the rounds, swap halves at the end.
    function automatic logic [15:0] model(input logic [15:0] p, input logic [127:0] k,
                                          input bit dec);
        logic [7:0] sk [16];
        logic [7:0] l, r, t;
        for (int i = 0; i < 16; i++) sk[i] = k[127 - 8*i -: 8];
        l = p[15:8];
        r = p[7:0];
        for (int i = 0; i < int'(Rounds); i++) begin
            t = r;
            r = l ^ (r ^ sk[dec ? int'(Rounds) - 1 - i : i]);
            l = t;
        end
        return {r, l};
    endfunction

    task automatic run_block(input logic [15:0] p, input logic [127:0] k, input bit dec,
                             input string tag, input bit do_ack, output logic [15:0] got);
        int n;
        bit seen;
        @(negedge clk);
        bus.pt = p;
        bus.key = k;
        bus.in_valid = 1'b1;
`ifdef FEISTEL_DECRYPT_EN
        decrypt = dec;
`endif
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.in_ready) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq({tag, " accept"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge; none of it may matter.
        bus.in_valid = 1'b0;
        bus.pt = 16'($urandom);
        bus.key = {$urandom, $urandom, $urandom, $urandom};
`ifdef FEISTEL_DECRYPT_EN
        decrypt = 1'($urandom);
`endif
        n = 1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) check_eq({tag, " busy"}, {bus.busy, bus.in_ready}, 32'b10);
            if (bus.out_valid) begin
                seen = 1'b1;
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.pt = 16'($urandom);
                @(posedge clk);
                n++;
            end
        end
        bus.in_valid = 1'b0;
        check_eq({tag, " latency"}, 32'(n), 32'(Rounds + 1));
        check_eq({tag, " ct"}, 32'(bus.ct), 32'(model(p, k, dec)));
        check_eq({tag, " done flags"}, {bus.busy, bus.in_ready}, 32'b00);
        got = bus.ct;
        if (do_ack) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            check_eq({tag, " back idle"}, {bus.in_ready, bus.out_valid}, 32'b10);
        end
    endtask

    initial begin
        logic [15:0]  got, held, enc;
        logic [127:0] rk;
        logic [15:0]  words [5];
        int           acc [5];
        int           nv;
        bit           seen;

        words = '{16'h6865, 16'h6C6C, 16'h6F77, 16'h6F72, 16'h6C64};
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.pt = '0;
        bus.key = '0;

        #12;
        check_eq("reset flags", {bus.in_ready, bus.busy, bus.out_valid}, 32'b100);
        check_eq("reset ct", 32'(bus.ct), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_block(16'h6865, 128'h0, 1'b0, "he zero key", 1'b1, got);
        check_eq("he vector", 32'(got), 32'h0D65);

        for (int t = 0; t < 6; t++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            run_block(16'($urandom), rk, 1'b0, "rand", 1'b1, got);
        end

        // Stall in DONE with a competing request on the input.
        run_block(16'h1234, {$urandom, $urandom, $urandom, $urandom}, 1'b0, "stall", 1'b0, held);
        bus.in_valid = 1'b1;
        bus.pt = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall ct", 32'(bus.ct), 32'(held));
            check_eq("stall flags", {bus.out_valid, bus.in_ready, bus.busy}, 32'b100);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq("stall release", {bus.in_ready, bus.out_valid}, 32'b10);

        // Reset in the middle of round 7.
        @(negedge clk);
        bus.pt = 16'hA5A5;
        bus.key = {$urandom, $urandom, $urandom, $urandom};
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrun rst flags", {bus.in_ready, bus.busy, bus.out_valid}, 32'b100);
        check_eq("midrun rst ct", 32'(bus.ct), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < int'(Rounds) + 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        check_eq("no partial result", 32'(nv), 32'd0);
        run_block(16'h5A5A, {$urandom, $urandom, $urandom, $urandom}, 1'b0, "post rst", 1'b1, got);

`ifdef FEISTEL_DECRYPT_EN
        rk = 128'h3F8A92B7_D4C1E609_F1AB34CD_7E58A3F2;
        run_block(16'h6C6C, rk, 1'b0, "enc ll", 1'b1, enc);
        run_block(enc, rk, 1'b1, "dec ll", 1'b1, got);
        check_eq("dec roundtrip", 32'(got), 32'h6C6C);
        decrypt = 1'b0;
`endif

        // Back-to-back stream with the consumer always ready.
        rk = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.key = rk;
        bus.out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            bus.pt = words[b];
            bus.in_valid = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                if (bus.in_ready) seen = 1'b1;
                else @(negedge clk);
            end
            check_eq("b2b accept", 32'(seen), 32'd1);
            acc[b] = cyc;
            if (b > 0) check_eq("b2b spacing", 32'(acc[b] - acc[b-1]), 32'(Rounds + 2));
            @(posedge clk);
            #1;
            bus.key = {$urandom, $urandom, $urandom, $urandom};
            if (b == 4) bus.in_valid = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1'b1;
            end
            check_eq("b2b ct", 32'(bus.ct), 32'(model(words[b], rk, 1'b0)));
            bus.key = rk;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
